sync_fifo_ctl: RTL and testbench

//  Parametrised single-clock FIFO, next generation of the 8-bit PicoBlaze-side buffer.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/sync_fifo_ctl_if.sv | 30 +++
 rtl/fifo_mem.sv | 21 ++
 rtl/sync_fifo_ctl.sv | 98 +++++++++
 tb/tb_sync_fifo_ctl.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the single-clock FIFO: pointer width function and status flag bundle.
package fifo_pkg;

  // Smallest pointer width able to address depth entries (at least one bit).
  function automatic int fifo_ptr_w(input int depth);
    int w;
    w = 1;
    while ((1 << w) < depth) w++;
    return w;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/sync_fifo_ctl_if.sv
// Handshake/status bundle between a FIFO client (master) and the FIFO controller (slave).
interface sync_fifo_ctl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [LW-1:0]         level;
  logic                  overflow;
  logic                  underflow;
  logic                  err_clr;

  modport master (
    output wr_en, din, rd_en, err_clr,
    input  dout, full, empty, almost_full, almost_empty, level, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en, err_clr,
    output dout, full, empty, almost_full, almost_empty, level, overflow, underflow
  );
endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one asynchronous read port.
module fifo_mem import fifo_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int PW         = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [PW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

  // Not reset: the controller never exposes an entry it has not written.
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO controller with level, almost flags and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module sync_fifo_ctl import fifo_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic           clk,
  input  logic           rst,
  sync_fifo_ctl_if.slave bus
);
  localparam int PW = fifo_ptr_w(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_ctl: DEPTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_ctl: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_ctl: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         level_q, next_level;
  fifo_status_t          st;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_acc, rd_acc;

  // Acceptance uses the registered flags, so full/empty arbitrate a same-cycle rd+wr.
  assign wr_acc = bus.wr_en && !st.full;
  assign rd_acc = bus.rd_en && !st.empty;

  always_comb begin
    next_level = level_q;
    if (wr_acc && !rd_acc)      next_level = level_q + 1'b1;
    else if (rd_acc && !wr_acc) next_level = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      st      <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1,
                   overflow: 1'b0, underflow: 1'b0};
    end else begin
      if (wr_acc) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      level_q         <= next_level;
      st.full         <= (next_level == DEPTH_L);
      st.empty        <= (next_level == '0);
      st.almost_full  <= (next_level >= AF_L);
      st.almost_empty <= (next_level <= AE_L);
      // Set beats clear so a rejection in the clearing cycle is not lost.
      if (bus.wr_en && st.full)  st.overflow <= 1'b1;
      else if (bus.err_clr)      st.overflow <= 1'b0;
      if (bus.rd_en && st.empty) st.underflow <= 1'b1;
      else if (bus.err_clr)      st.underflow <= 1'b0;
    end
  end

  fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .PW(PW)) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (bus.din),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

`ifdef FIFO_FWFT_EN
  assign bus.dout = st.empty ? '0 : rd_data;
`else
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (rst)         dout_q <= '0;
    else if (rd_acc) dout_q <= rd_data;
  end

  assign bus.dout = dout_q;
`endif

  assign bus.full         = st.full;
  assign bus.empty        = st.empty;
  assign bus.almost_full  = st.almost_full;
  assign bus.almost_empty = st.almost_empty;
  assign bus.level        = level_q;
  assign bus.overflow     = st.overflow;
  assign bus.underflow    = st.underflow;
endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Directed plus random stimulus for sync_fifo_ctl, checked against a queue-based model.
module tb_sync_fifo_ctl;
  localparam int DW = 8, DEPTH = 16, AF = 14, AE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_ctl_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  sync_fifo_ctl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q[$];
  logic          m_ovf  = 1'b0;
  logic          m_unf  = 1'b0;
  logic [DW-1:0] m_dout = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("level", 32'(bus.level), 32'(n));
    chk("full", 32'(bus.full), 32'(n == DEPTH));
    chk("empty", 32'(bus.empty), 32'(n == 0));
    chk("almost_full", 32'(bus.almost_full), 32'(n >= AF));
    chk("almost_empty", 32'(bus.almost_empty), 32'(n <= AE));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("underflow", 32'(bus.underflow), 32'(m_unf));
`ifdef FIFO_FWFT_EN
    chk("dout", 32'(bus.dout), (n > 0) ? 32'(q[0]) : 32'd0);
`else
    chk("dout", 32'(bus.dout), 32'(m_dout));
`endif
  endtask

  // Apply one cycle of inputs, advance the model by the FIFO rules, then compare.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic c, input logic rs);
    logic was_full, was_empty;
    bus.wr_en = w; bus.din = d; bus.rd_en = r; bus.err_clr = c; rst = rs;
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (rs) begin
      q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;
    end else begin
      if (r && !was_empty) m_dout = q.pop_front();
      if (w && !was_full)  q.push_back(d);
      if (w && was_full) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
      if (r && was_empty) m_unf = 1'b1; else if (c) m_unf = 1'b0;
    end
    #1;
    check_all();
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.din = '0; bus.rd_en = 1'b0; bus.err_clr = 1'b0;

    step(0, 8'h00, 0, 0, 1);
    step(1, 8'h33, 1, 1, 1);
    step(0, 8'h00, 0, 0, 0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_almost_empty", 32'(bus.almost_empty), 32'd1);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_dout", 32'(bus.dout), 32'd0);
    chk("rst_errors", 32'({bus.overflow, bus.underflow}), 32'd0);

    for (int i = 0; i < 16; i++) begin
      step(1, 8'(i), 0, 0, 0);
      if (i == 1)  chk("ae_at_2", 32'(bus.almost_empty), 32'd1);
      if (i == 2)  chk("ae_at_3", 32'(bus.almost_empty), 32'd0);
      if (i == 12) chk("af_at_13", 32'(bus.almost_full), 32'd0);
      if (i == 13) chk("af_at_14", 32'(bus.almost_full), 32'd1);
    end
    chk("full_16", 32'(bus.full), 32'd1);
    chk("level_16", 32'(bus.level), 32'd16);

    step(1, 8'hEE, 0, 0, 0);
    chk("ovf_level", 32'(bus.level), 32'd16);
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    step(0, 8'h00, 0, 1, 0);
    chk("ovf_clr", 32'(bus.overflow), 32'd0);

    // Read and write together while full: only the read goes through.
    step(1, 8'hEE, 1, 0, 0);
    chk("full_rw_level", 32'(bus.level), 32'd15);
    chk("full_rw_ovf", 32'(bus.overflow), 32'd1);
    step(0, 8'h00, 0, 1, 0);

    for (int i = 1; i < 16; i++) begin
      step(0, 8'h00, 1, 0, 0);
`ifndef FIFO_FWFT_EN
      chk("order", 32'(bus.dout), 32'(i));
`endif
    end
    chk("drained_empty", 32'(bus.empty), 32'd1);

    step(0, 8'h00, 1, 0, 0);
    chk("unf_set", 32'(bus.underflow), 32'd1);
`ifndef FIFO_FWFT_EN
    chk("unf_dout_held", 32'(bus.dout), 32'h0F);
`endif
    // Read and write together while empty: only the write goes through.
    step(1, 8'h5A, 1, 0, 0);
    chk("empty_rw_level", 32'(bus.level), 32'd1);
    step(0, 8'h00, 0, 1, 0);
    chk("unf_clr", 32'(bus.underflow), 32'd0);
    step(0, 8'h00, 1, 0, 0);

    step(1, 8'hA5, 0, 0, 0);
    chk("single_empty", 32'(bus.empty), 32'd0);
`ifdef FIFO_FWFT_EN
    chk("fwft_head", 32'(bus.dout), 32'hA5);
`endif
    step(0, 8'h00, 1, 0, 0);

    // 40 writes / 40 reads interleaved, pointers wrap several times.
    for (int i = 0; i < 5; i++)  step(1, 8'($urandom), 0, 0, 0);
    for (int i = 0; i < 35; i++) step(1, 8'($urandom), 1, 0, 0);
    for (int i = 0; i < 5; i++)  step(0, 8'h00, 1, 0, 0);
    chk("wrap_no_err", 32'({bus.overflow, bus.underflow}), 32'd0);

    for (int i = 0; i < 8; i++) step(1, 8'($urandom), 0, 0, 0);
    step(1, 8'h77, 1, 0, 0);
    chk("rw_level_8", 32'(bus.level), 32'd8);

    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = (i / 100) % 2 == 0 ? 65 : 35;
      step(logic'($urandom_range(0, 99) < bias), 8'($urandom),
           logic'($urandom_range(0, 99) < 100 - bias),
           logic'($urandom_range(0, 15) == 0), logic'($urandom_range(0, 199) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
